// File: rtl/hwpe_stream_addressgen_nd.sv
// N-dimensional streamer address generator: sweeps an NB_DIM box of word-aligned
// addresses with byte strobes, one beat per valid/ready handshake, from start to done.
module hwpe_stream_addressgen_nd #(
  parameter int unsigned NB_DIM = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned STEP   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  input  logic [NB_DIM*CNT_W-1:0]      len_i,
  input  logic [(NB_DIM-1)*ADDR_W-1:0] stride_i,
  output logic [ADDR_W-1:0]            addr_o,
  output logic [STEP-1:0]              strb_o,
  output logic [NB_DIM-1:0]            dim_last_o,
  output logic                         last_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int unsigned SW = $clog2(STEP);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  typedef logic [CNT_W:0]    cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  state_e             state_q, state_d;
  addr_t              base_q, base_d;
  addr_t [NB_DIM-2:0] stride_q, stride_d;
  cnt_t  [NB_DIM-1:0] len_q, len_d;  // len_q[0] is L0, including the extra misaligned beat
  logic               mis_q, mis_d;
  cnt_t  [NB_DIM-1:0] cnt_q, cnt_d;
  addr_t [NB_DIM-1:0] off_q, off_d;
  addr_t [NB_DIM-1:0] inc_s;
  logic  [NB_DIM-1:0] fin_s;
  logic               any_zero_s, carry_s;

  addr_t              line_s, byte_s;
  logic  [SW-1:0]     o_s;
  logic  [STEP-1:0]   ones_s;
  addr_t              addr_q, addr_d;
  logic  [STEP-1:0]   strb_q, strb_d;
  logic  [NB_DIM-1:0] dim_last_q, dim_last_d;
  logic               last_q, last_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;

  // FSM next state, configuration latch and nested-loop counter/offset advance.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    stride_d   = stride_q;
    len_d      = len_q;
    mis_d      = mis_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    any_zero_s = 1'b0;
    carry_s    = 1'b1;
    inc_s[0]   = addr_t'(STEP);
    for (int d = 1; d < NB_DIM; d++) begin
      inc_s[d] = stride_q[d-1];
    end
    for (int d = 0; d < NB_DIM; d++) begin
      fin_s[d] = (cnt_q[d] == len_q[d] - cnt_t'(1));
    end
    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d   = base_addr_i;
          stride_d = stride_i;
          mis_d    = |base_addr_i[SW-1:0];
          for (int d = 0; d < NB_DIM - 1; d++) begin
            mis_d = mis_d | (|stride_i[d*ADDR_W +: SW]);
          end
          for (int d = 0; d < NB_DIM; d++) begin
            len_d[d]   = {1'b0, len_i[d*CNT_W +: CNT_W]};
            any_zero_s = any_zero_s | (len_i[d*CNT_W +: CNT_W] == {CNT_W{1'b0}});
          end
          len_d[0] = len_d[0] + cnt_t'(mis_d);
          cnt_d    = '0;
          off_d    = '0;
          state_d  = any_zero_s ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (ready_i) begin
          if (&fin_s) begin
            state_d = DONE;
          end else begin
            // Ripple carry through the loops: a dim at its final value wraps and passes the carry on.
            for (int d = 0; d < NB_DIM; d++) begin
              if (carry_s) begin
                if (fin_s[d]) begin
                  cnt_d[d] = '0;
                  off_d[d] = '0;
                end else begin
                  cnt_d[d] = cnt_q[d] + cnt_t'(1);
                  off_d[d] = off_q[d] + inc_s[d];
                  carry_s  = 1'b0;
                end
              end else begin
                cnt_d[d] = cnt_q[d];
              end
            end
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the beat that will be presented after this edge.
  always_comb begin
    line_s = base_d;
    for (int d = 1; d < NB_DIM; d++) begin
      line_s = line_s + off_d[d];
    end
    byte_s  = line_s + off_d[0];
    o_s     = line_s[SW-1:0];
    ones_s  = {STEP{1'b1}};
    valid_d = (state_d == RUN);
    busy_d  = valid_d;
    done_d  = (state_d == DONE);
    for (int d = 0; d < NB_DIM; d++) begin
      dim_last_d[d] = valid_d & (cnt_d[d] == len_d[d] - cnt_t'(1));
    end
    last_d = valid_d & (&dim_last_d);
    addr_d = valid_d ? {byte_s[ADDR_W-1:SW], {SW{1'b0}}} : '0;
    if (!valid_d) begin
      strb_d = '0;
    end else if (!mis_d) begin
      strb_d = ones_s;
    end else if (cnt_d[0] == '0) begin
      strb_d = ones_s << o_s;
    end else if (cnt_d[0] == len_d[0] - cnt_t'(1)) begin
      strb_d = ~(ones_s << o_s);
    end else begin
      strb_d = ones_s;
    end
  end

  // State, configuration, counters and registered outputs; clear acts exactly like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= IDLE;
      base_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      mis_q      <= 1'b0;
      cnt_q      <= '0;
      off_q      <= '0;
      addr_q     <= '0;
      strb_q     <= '0;
      dim_last_q <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      addr_q     <= addr_d;
      strb_q     <= strb_d;
      dim_last_q <= dim_last_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign addr_o     = addr_q;
  assign strb_o     = strb_q;
  assign dim_last_o = dim_last_q;
  assign last_o     = last_q;
  assign valid_o    = valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_hwpe_stream_addressgen_nd.sv
// Self-checking bench for hwpe_stream_addressgen_nd: nested-loop reference model,
// directed scenarios and randomized configurations with random backpressure.
module tb_hwpe_stream_addressgen_nd;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [2:0]  dl;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_i, clear_i, start_i, ready_i;
  logic [31:0] base_addr_i;
  logic [47:0] len_i;
  logic [63:0] stride_i;
  logic [31:0] addr_o;
  logic [3:0]  strb_o;
  logic [2:0]  dim_last_o;
  logic        last_o, valid_o, busy_o, done_o;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    holds, busy_bad, done_gap, first_lat;
  bit    timeout;

  always #5 clk = ~clk;

  hwpe_stream_addressgen_nd #(.NB_DIM(3), .ADDR_W(32), .CNT_W(16), .STEP(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .len_i(len_i), .stride_i(stride_i),
    .addr_o(addr_o), .strb_o(strb_o), .dim_last_o(dim_last_o), .last_o(last_o),
    .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  // Drive a configuration and build the expected beat list with plain nested loops.
  task automatic set_cfg(input logic [31:0] b, input int l0, input int l1, input int l2,
                         input logic [31:0] s1, input logic [31:0] s2);
    logic [31:0] line;
    logic [3:0]  sm;
    beat_t       t;
    bit          mis;
    int          len0;
    base_addr_i = b;
    len_i       = {16'(l2), 16'(l1), 16'(l0)};
    stride_i    = {s2, s1};
    exp_q.delete();
    mis  = ((b | s1 | s2) & 32'h3) != 32'h0;
    len0 = l0 + (mis ? 1 : 0);
    for (int i2 = 0; i2 < l2; i2++)
      for (int i1 = 0; i1 < l1; i1++)
        for (int i0 = 0; i0 < len0; i0++) begin
          line   = b + 32'(i1) * s1 + 32'(i2) * s2;
          t.addr = (line + 32'(i0 * 4)) & 32'hFFFF_FFFC;
          sm     = 4'hF << line[1:0];
          if (!mis)              t.strb = 4'hF;
          else if (i0 == 0)      t.strb = sm;
          else if (i0 == len0-1) t.strb = ~sm;
          else                   t.strb = 4'hF;
          t.dl   = {i2 == l2 - 1, i1 == l1 - 1, i0 == len0 - 1};
          t.last = &t.dl;
          exp_q.push_back(t);
        end
  endtask

  // Pulse start, then record accepted beats, stall stability, latency and done timing.
  task automatic collect(input int rmode, input int clear_at, input bit start_mid, input int budget);
    beat_t cur, prev;
    bit    stalled;
    int    cyc, last_acc;
    obs_q.delete();
    holds = 0; busy_bad = 0; done_gap = -1; first_lat = -1; timeout = 1'b0;
    stalled = 1'b0; last_acc = -1; cyc = 0; prev = '0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    while (1) begin
      if (cyc >= budget) begin timeout = 1'b1; break; end
      if (valid_o) begin
        cur = '{addr: addr_o, strb: strb_o, dl: dim_last_o, last: last_o};
        if (first_lat < 0) first_lat = cyc;
        if (!busy_o) busy_bad++;
        if (stalled && cur !== prev) holds++;
        if (clear_at >= 0 && obs_q.size() == clear_at) begin
          clear_i = 1'b1; @(negedge clk); clear_i = 1'b0; break;
        end
        case (rmode)
          0:       ready_i = 1'b1;
          1:       ready_i = (cyc % 2 == 0);
          default: ready_i = 1'($urandom_range(0, 1));
        endcase
        if (start_mid && cyc == 2) begin
          start_i = 1'b1; base_addr_i = base_addr_i ^ 32'h1000;
        end
        if (ready_i) begin obs_q.push_back(cur); stalled = 1'b0; last_acc = cyc; end
        else begin stalled = 1'b1; prev = cur; end
      end else if (done_o) begin
        done_gap = cyc - last_acc; break;
      end
      cyc++;
      @(negedge clk); start_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
    base_addr_i = '0; len_i = '0; stride_i = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({addr_o, strb_o, dim_last_o, last_o, valid_o, busy_o, done_o} !== 43'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", {addr_o, strb_o, dim_last_o, last_o, valid_o, busy_o, done_o});
    end
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({valid_o, busy_o, done_o} !== 3'b000) begin
      n_err++; $display("FAIL idle_after_reset: got %b want 000", {valid_o, busy_o, done_o});
    end
  endtask

  task automatic test_basic();
    logic [31:0] ref_addr [6] = '{32'h100, 32'h104, 32'h108, 32'h140, 32'h144, 32'h148};
    set_cfg(32'h100, 3, 2, 1, 32'h40, 32'h400);
    collect(0, -1, 1'b0, 100);
    n_cmp++; if (timeout) begin n_err++; $display("FAIL basic_timeout: got timeout want done"); end
    n_cmp++; if (obs_q.size() !== 6) begin n_err++; $display("FAIL basic_count: got %0d want 6", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL basic_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i].addr !== ref_addr[i]) begin n_err++; $display("FAIL basic_addr%0d: got %h want %h", i, obs_q[i].addr, ref_addr[i]); end
    end
    n_cmp++; if (first_lat !== 0) begin n_err++; $display("FAIL basic_latency: got %0d want 0", first_lat); end
    n_cmp++; if (done_gap !== 1) begin n_err++; $display("FAIL basic_done_gap: got %0d want 1", done_gap); end
    n_cmp++; if (busy_bad !== 0) begin n_err++; $display("FAIL basic_busy: got %0d want 0", busy_bad); end
    @(negedge clk);
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", done_o); end
  endtask

  task automatic test_misaligned();
    set_cfg(32'h102, 2, 1, 1, 32'h0, 32'h0);
    collect(0, -1, 1'b0, 100);
    n_cmp++; if (obs_q.size() !== 3) begin n_err++; $display("FAIL mis_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mis_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() == 3) begin
      n_cmp++;
      if ({obs_q[0].strb, obs_q[1].strb, obs_q[2].strb, obs_q[2].addr, obs_q[2].last} !== {12'hCF3, 32'h108, 1'b1}) begin
        n_err++; $display("FAIL mis_strobes: got %h%h%h last@%h=%b want CF3 last@108", obs_q[0].strb, obs_q[1].strb, obs_q[2].strb, obs_q[2].addr, obs_q[2].last);
      end
    end
  endtask

  task automatic test_backpressure();
    set_cfg(32'h100, 3, 2, 1, 32'h40, 32'h400);
    collect(1, -1, 1'b0, 100);
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (holds !== 0) begin n_err++; $display("FAIL bp_hold: got %0d changes want 0", holds); end
    n_cmp++; if (done_gap !== 1) begin n_err++; $display("FAIL bp_done_gap: got %0d want 1", done_gap); end
  endtask

  task automatic test_neg_stride();
    logic [31:0] bases [2] = '{32'h40, 32'h0};
    logic [31:0] want  [2][2] = '{'{32'h40, 32'h20}, '{32'h0, 32'hFFFF_FFE0}};
    for (int k = 0; k < 2; k++) begin
      set_cfg(bases[k], 1, 2, 1, 32'hFFFF_FFE0, 32'h0);
      collect(0, -1, 1'b0, 100);
      n_cmp++; if (obs_q.size() !== 2) begin n_err++; $display("FAIL neg_count%0d: got %0d want 2", k, obs_q.size()); end
      for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
        n_cmp++; if (obs_q[i] !== exp_q[i] || obs_q[i].addr !== want[k][i]) begin
          n_err++; $display("FAIL neg_beat%0d_%0d: got %h want addr %h", k, i, obs_q[i], want[k][i]);
        end
      end
    end
  endtask

  task automatic test_zero_len_and_start_in_run();
    set_cfg(32'h200, 2, 0, 2, 32'h10, 32'h100);
    collect(0, -1, 1'b0, 20);
    n_cmp++; if (obs_q.size() !== 0 || first_lat !== -1) begin n_err++; $display("FAIL zero_len_beats: got %0d want 0", obs_q.size()); end
    n_cmp++; if (done_gap !== 1) begin n_err++; $display("FAIL zero_len_done: got %0d want 1", done_gap); end
    set_cfg(32'h100, 3, 2, 1, 32'h40, 32'h400);
    collect(1, -1, 1'b1, 100);
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL start_in_run_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL start_in_run_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL start_in_run_queued: got valid %b want 0", valid_o); end
    end
  endtask

  task automatic test_clear();
    bit saw_done;
    set_cfg(32'h100, 3, 2, 1, 32'h40, 32'h400);
    collect(0, 3, 1'b0, 100);
    n_cmp++; if (obs_q.size() !== 3) begin n_err++; $display("FAIL clear_beats: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 3; i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL clear_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++;
    if ({addr_o, strb_o, dim_last_o, last_o, valid_o, busy_o, done_o} !== 43'h0) begin
      n_err++; $display("FAIL clear_outputs: got %h want 0", {addr_o, strb_o, dim_last_o, last_o, valid_o, busy_o, done_o});
    end
    saw_done = 1'b0;
    repeat (4) begin @(negedge clk); saw_done = saw_done | done_o | valid_o; end
    n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL clear_no_done: got activity %b want 0", saw_done); end
    set_cfg(32'h100, 3, 2, 1, 32'h40, 32'h400);
    clear_i = 1'b1; start_i = 1'b1;
    @(negedge clk); clear_i = 1'b0; start_i = 1'b0;
    n_cmp++; if ({valid_o, busy_o} !== 2'b00) begin n_err++; $display("FAIL clear_wins_start: got %b want 00", {valid_o, busy_o}); end
    @(negedge clk);
    n_cmp++; if ({valid_o, done_o} !== 2'b00) begin n_err++; $display("FAIL clear_wins_start_late: got %b want 00", {valid_o, done_o}); end
  endtask

  task automatic test_long_line();
    int n_dl0;
    set_cfg(32'h1, 16'hFFFF, 1, 1, 32'h0, 32'h0);
    collect(0, -1, 1'b0, 70000);
    n_cmp++; if (obs_q.size() !== 32'h10000) begin n_err++; $display("FAIL long_count: got %0d want 65536", obs_q.size()); end
    n_dl0 = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i].dl[0]) n_dl0++;
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL long_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (n_dl0 !== 1) begin n_err++; $display("FAIL long_dim_last0: got %0d want 1", n_dl0); end
    n_cmp++; if (done_gap !== 1) begin n_err++; $display("FAIL long_done_gap: got %0d want 1", done_gap); end
  endtask

  task automatic test_random();
    logic [31:0] b, s1, s2;
    for (int k = 0; k < 10; k++) begin
      b  = $urandom;
      if ($urandom_range(0, 1) == 1) b = b & 32'hFFFF_FFFC;
      s1 = ($urandom_range(0, 2) != 0) ? 32'($urandom_range(0, 64)) * 32'd4 : 32'($urandom);
      s2 = ($urandom_range(0, 2) != 0) ? 32'($urandom_range(0, 64)) * 32'd4 : 32'($urandom);
      set_cfg(b, $urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(1, 3), s1, s2);
      collect(2, -1, 1'b0, 2000);
      n_cmp++; if (timeout || obs_q.size() !== exp_q.size()) begin
        n_err++; $display("FAIL rand%0d_count: got %0d want %0d", k, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_beat%0d: got %h want %h", k, i, obs_q[i], exp_q[i]); end
      end
      n_cmp++; if (holds !== 0 || done_gap !== 1) begin
        n_err++; $display("FAIL rand%0d_handshake: got holds %0d gap %0d want 0/1", k, holds, done_gap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_misaligned();
    test_backpressure();
    test_neg_stride();
    test_zero_len_and_start_in_run();
    test_clear();
    test_random();
    test_long_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
